// File: rtl/noc_pkg.sv
// Router-wide constants shared by the input buffers, switch allocator and crossbar.
package noc_pkg;

    localparam int NUM_PORTS = 7;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_N     = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_W     = 4;
    localparam int PORT_UP    = 5;
    localparam int PORT_DOWN  = 6;

    // Encoded as {tail, head}, so a single-flit packet is both.
    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
interface switch_allocator_if
    import noc_pkg::*;
#(
    parameter int P = NUM_PORTS
) ();

    logic [P-1:0]   req_valid_all;
    logic [P*P-1:0] req_outport_all;
    logic [P-1:0]   req_head_all;
    logic [P-1:0]   req_tail_all;
    logic [P-1:0]   out_ready_all;
    logic [P*P-1:0] grant_outport_all;
    logic [P-1:0]   grant_inport_all;
    logic [P-1:0]   lock_all;
    logic           proto_err;

    modport slave (
        input  req_valid_all, req_outport_all, req_head_all, req_tail_all, out_ready_all,
        output grant_outport_all, grant_inport_all, lock_all, proto_err
    );

    modport master (
        output req_valid_all, req_outport_all, req_head_all, req_tail_all, out_ready_all,
        input  grant_outport_all, grant_inport_all, lock_all, proto_err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the one-hot pointer wins,
// wrapping around, using the double-width subtract-and-mask trick.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ptr_i,
    output logic [N-1:0] gnt_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;

    // The borrow from subtracting the pointer clears every request bit up to the winner.
    assign req_dbl = {req_i, req_i};
    assign gnt_dbl = req_dbl & ~(req_dbl - {{N{1'b0}}, ptr_i});
    assign gnt_o   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per output, round-robin among head flits, then the
// output stays locked to the winning input until its tail flit has been transferred.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int P = NUM_PORTS
) (
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  bus
);

    // All [o][i] matrices: outer index is the output port, inner the input port.
    logic [P-1:0]        lock_q, lock_d;
    logic [P-1:0][P-1:0] owner_q, owner_d;
    logic [P-1:0][P-1:0] rr_ptr_q, rr_ptr_d;
    logic                proto_err_q, proto_err_d;

    logic [P-1:0][P-1:0] elig;
    logic [P-1:0][P-1:0] head_elig;
    logic [P-1:0][P-1:0] arb_gnt;
    logic [P-1:0][P-1:0] gnt;
    logic [P-1:0]        err_vec;

    function automatic logic [P-1:0] rotl1(input logic [P-1:0] v);
        return {v[P-2:0], v[P-1]};
    endfunction

    always_comb begin
        for (int o = 0; o < P; o++) begin
            for (int i = 0; i < P; i++) begin
                elig[o][i] = bus.req_valid_all[i] & bus.req_outport_all[i*P+o];
            end
            head_elig[o] = elig[o] & bus.req_head_all;
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_arb
        rr_arbiter #(.N(P)) u_rr_arbiter (
            .req_i (head_elig[o]),
            .ptr_i (rr_ptr_q[o]),
            .gnt_o (arb_gnt[o])
        );
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt      = '0;
        err_vec  = '0;
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        for (int o = 0; o < P; o++) begin
            // A body/tail flit is only legal towards the output its own packet holds.
            for (int i = 0; i < P; i++) begin
                if (elig[o][i] && !bus.req_head_all[i] && !(lock_q[o] && owner_q[o][i])) begin
                    err_vec[o] = 1'b1;
                end
            end
            if (bus.out_ready_all[o]) begin
                if (lock_q[o]) begin
                    if ((elig[o] & owner_q[o]) != '0) begin
                        gnt[o] = owner_q[o];
                        if ((owner_q[o] & bus.req_tail_all) != '0) begin
                            lock_d[o]  = 1'b0;
                            owner_d[o] = '0;
                        end
                    end
                end else if (arb_gnt[o] != '0) begin
                    gnt[o]      = arb_gnt[o];
                    rr_ptr_d[o] = rotl1(arb_gnt[o]);
                    if ((arb_gnt[o] & bus.req_tail_all) == '0) begin
                        lock_d[o]  = 1'b1;
                        owner_d[o] = arb_gnt[o];
                    end
                end
            end
        end
        proto_err_d = proto_err_q | (|err_vec);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q      <= '0;
            owner_q     <= '0;
            proto_err_q <= 1'b0;
            for (int o = 0; o < P; o++) begin
                rr_ptr_q[o] <= P'(1);
            end
        end else begin
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        bus.grant_inport_all = '0;
        for (int o = 0; o < P; o++) begin
            for (int i = 0; i < P; i++) begin
                bus.grant_outport_all[o*P+i] = gnt[o][i] & ~rst;
                bus.grant_inport_all[i]      = bus.grant_inport_all[i] | (gnt[o][i] & ~rst);
            end
        end
    end

    assign bus.lock_all  = lock_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a driver queues hand-computed expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_switch_allocator;
    import noc_pkg::*;

    localparam int P = NUM_PORTS;

    typedef struct {
        string          name;
        logic [P*P-1:0] go;
        logic [P-1:0]   gi;
        logic [P-1:0]   lk;
        logic           err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_allocator_if #(.P(P)) bus ();

    switch_allocator #(.P(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [P-1:0]   s_valid, s_head, s_tail, s_ready;
    logic [P*P-1:0] s_outport;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < P; i++) begin
            if (bus.req_valid_all[i] && !rst) begin
                assert ($onehot(bus.req_outport_all[i*P +: P]))
                    else $error("FAIL req_outport not one-hot for input %0d", i);
            end
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".grant_outport"}, 64'(bus.grant_outport_all), 64'(e.go));
            check({e.name, ".grant_inport"},  64'(bus.grant_inport_all),  64'(e.gi));
            check({e.name, ".lock"},          64'(bus.lock_all),          64'(e.lk));
            check({e.name, ".proto_err"},     64'(bus.proto_err),         64'(e.err));
        end
    end

    function automatic logic [P*P-1:0] gb(input int o, input int i);
        logic [P*P-1:0] one;
        one = 1;
        return one << (o*P + i);
    endfunction

    task automatic clear_reqs();
        s_valid   = '0;
        s_outport = '0;
        s_head    = '0;
        s_tail    = '0;
        s_ready   = '1;
    endtask

    task automatic add_req(input int i, input int o, input bit h, input bit t);
        s_valid[i]         = 1'b1;
        s_outport[i*P + o] = 1'b1;
        s_head[i]          = h;
        s_tail[i]          = t;
    endtask

    task automatic step(input string nm, input bit rst_v, input logic [P*P-1:0] go,
                        input logic [P-1:0] gi, input logic [P-1:0] lk, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = rst_v;
        bus.req_valid_all   = s_valid;
        bus.req_outport_all = s_outport;
        bus.req_head_all    = s_head;
        bus.req_tail_all    = s_tail;
        bus.out_ready_all   = s_ready;
        e.name = nm;
        e.go   = go;
        e.gi   = gi;
        e.lk   = lk;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Round-robin table on output 0: requesting inputs and the expected winner.
    logic [P-1:0] rr_reqs [6];
    int           rr_win  [6];

    initial begin
        rr_reqs = '{7'b0101010, 7'b0101010, 7'b0101010, 7'b1000001, 7'b1000001, 7'b0101010};
        rr_win  = '{1, 3, 5, 6, 0, 1};

        clear_reqs();
        bus.req_valid_all   = '0;
        bus.req_outport_all = '0;
        bus.req_head_all    = '0;
        bus.req_tail_all    = '0;
        bus.out_ready_all   = '1;

        // Reset held with random (one-hot) requests: everything stays quiet.
        for (int k = 0; k < 3; k++) begin
            s_valid = P'($urandom);
            s_head  = P'($urandom);
            s_tail  = P'($urandom);
            s_ready = P'($urandom);
            for (int i = 0; i < P; i++) begin
                s_outport[i*P +: P] = P'(1) << $urandom_range(P-1, 0);
            end
            step("reset_rand", 1'b1, '0, '0, '0, 1'b0);
        end
        clear_reqs();
        step("idle_after_rst", 1'b0, '0, '0, '0, 1'b0);

        // Single-flit packet, then show ptr of output 4 moved on to input 3.
        clear_reqs(); add_req(2, 4, 1, 1);
        step("single_flit", 1'b0, gb(4, 2), 7'b0000100, '0, 1'b0);
        clear_reqs(); add_req(2, 4, 1, 1); add_req(3, 4, 1, 1);
        step("ptr4_next_in3", 1'b0, gb(4, 3), 7'b0001000, '0, 1'b0);

        // Contention on output 0, including the 6 -> 0 wrap.
        for (int k = 0; k < 6; k++) begin
            clear_reqs();
            for (int i = 0; i < P; i++) begin
                if (rr_reqs[k][i]) add_req(i, 0, 1, 1);
            end
            step($sformatf("rr_out0_%0d", k), 1'b0, gb(0, rr_win[k]), P'(1) << rr_win[k], '0, 1'b0);
        end

        // Wormhole: in0 4-flit packet on output 1 while in2 waits with a head.
        clear_reqs(); add_req(0, 1, 1, 0); add_req(2, 1, 1, 1);
        step("wh_head", 1'b0, gb(1, 0), 7'b0000001, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            clear_reqs(); add_req(0, 1, 0, 0); add_req(2, 1, 1, 1);
            step($sformatf("wh_body_%0d", k), 1'b0, gb(1, 0), 7'b0000001, 7'b0000010, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            clear_reqs(); add_req(0, 1, 0, 0); add_req(2, 1, 1, 1); s_ready[1] = 1'b0;
            step($sformatf("wh_stall_%0d", k), 1'b0, '0, '0, 7'b0000010, 1'b0);
        end
        clear_reqs(); add_req(0, 1, 0, 1); add_req(2, 1, 1, 1);
        step("wh_tail", 1'b0, gb(1, 0), 7'b0000001, 7'b0000010, 1'b0);
        clear_reqs(); add_req(2, 1, 1, 1);
        step("wh_next_pkt", 1'b0, gb(1, 2), 7'b0000100, '0, 1'b0);

        // Asynchronous reset in the middle of a packet drops the lock at once.
        clear_reqs(); add_req(0, 1, 1, 0);
        step("ar_head", 1'b0, gb(1, 0), 7'b0000001, '0, 1'b0);
        clear_reqs(); add_req(0, 1, 0, 0);
        step("ar_body", 1'b0, gb(1, 0), 7'b0000001, 7'b0000010, 1'b0);
        step("ar_in_reset", 1'b1, '0, '0, '0, 1'b0);
        clear_reqs();
        step("ar_released", 1'b0, '0, '0, '0, 1'b0);

        // Body flit to an unlocked output: refused, and the error is sticky.
        clear_reqs(); add_req(4, 2, 0, 0);
        step("err_body_unlocked", 1'b0, '0, '0, '0, 1'b0);
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            step($sformatf("err_sticky_%0d", k), 1'b0, '0, '0, '0, 1'b1);
        end

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
